// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decoder.
//   Owns the fetch PC, keeps at most one request outstanding to instruction
//   memory, buffers returned words with their PC in a DEPTH-entry FIFO and
//   presents the head to decode over valid/ready. A redirect flushes the
//   buffer and discards any response still in flight.
// Ports:
//   clk, rst                  clock (rising edge), async active-low reset
//   imem_req/imem_addr        fetch request, held with a stable address until ack
//   imem_ack/imem_data        response strobe and instruction word
//   redirect/redirect_pc      one-cycle restart of fetch at a new address
//   instr/instr_pc            head-of-buffer word and its PC
//   instr_valid/instr_ready   decode handshake (head popped when both high)
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW   = PW + 1;

  // IDLE: nothing outstanding; WAIT: response kept; DROP: response discarded
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] fetch_pc_nxt;
  logic            req_nxt;
  logic [XLEN-1:0] addr_nxt;

  logic [XLEN-1:0] mem_data [DEPTH];
  logic [XLEN-1:0] mem_pc   [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr_nxt;
  logic [PW-1:0]   wr_ptr_nxt;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;

  logic [XLEN-1:0] rpc_c;
  logic [XLEN-1:0] pc_inc_c;
  logic [XLEN-1:0] target_c;
  logic            ack_c;
  logic            push_c;
  logic            pop_c;
  logic            can_issue_c;
  logic            head_fresh_c;
  logic [XLEN-1:0] head_data_c;
  logic [XLEN-1:0] head_pc_c;

  // Buffer bookkeeping: redirect voids push and pop and empties the FIFO
  always_comb begin : buf_ctl
    rpc_c    = redirect_pc & ~32'h0000_0003;
    pc_inc_c = fetch_pc + 32'd4;
    ack_c    = imem_req & imem_ack;
    push_c   = (state == WAIT) & ack_c & ~redirect;
    pop_c    = instr_valid & instr_ready & ~redirect;
    count_nxt  = count;
    rd_ptr_nxt = rd_ptr;
    wr_ptr_nxt = wr_ptr;
    if (redirect) begin
      count_nxt  = '0;
      rd_ptr_nxt = '0;
      wr_ptr_nxt = '0;
    end else begin
      count_nxt = count + CW'(push_c) - CW'(pop_c);
      if (pop_c) begin
        rd_ptr_nxt = rd_ptr + PW'(1);
      end
      if (push_c) begin
        wr_ptr_nxt = wr_ptr + PW'(1);
      end
    end
    // A request may only go out if its response is guaranteed a slot
    can_issue_c = (count_nxt < CW'(DEPTH));
    // Post-edge head is the word being pushed when the buffer drains to it
    head_fresh_c = push_c & (wr_ptr == rd_ptr_nxt);
    head_data_c  = head_fresh_c ? imem_data : mem_data[rd_ptr_nxt];
    head_pc_c    = head_fresh_c ? fetch_pc  : mem_pc[rd_ptr_nxt];
  end

  // Next-state and request logic
  always_comb begin : fsm_comb
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    req_nxt      = imem_req;
    addr_nxt     = imem_addr;
    target_c     = redirect ? rpc_c : fetch_pc;
    case (state)
      IDLE: begin
        if (redirect) begin
          fetch_pc_nxt = rpc_c;
          state_nxt    = WAIT;
          req_nxt      = 1'b1;
          addr_nxt     = rpc_c;
        end else if (can_issue_c) begin
          state_nxt = WAIT;
          req_nxt   = 1'b1;
          addr_nxt  = fetch_pc;
        end
      end
      WAIT: begin
        if (ack_c) begin
          if (redirect) begin
            fetch_pc_nxt = rpc_c;
            req_nxt      = 1'b1;
            addr_nxt     = rpc_c;
          end else begin
            fetch_pc_nxt = pc_inc_c;
            if (can_issue_c) begin
              req_nxt  = 1'b1;
              addr_nxt = pc_inc_c;
            end else begin
              state_nxt = IDLE;
              req_nxt   = 1'b0;
            end
          end
        end else if (redirect) begin
          // Old request stays on the bus; its response will be thrown away
          fetch_pc_nxt = rpc_c;
          state_nxt    = DROP;
        end
      end
      DROP: begin
        fetch_pc_nxt = target_c;
        if (ack_c) begin
          if (can_issue_c) begin
            state_nxt = WAIT;
            req_nxt   = 1'b1;
            addr_nxt  = target_c;
          end else begin
            state_nxt = IDLE;
            req_nxt   = 1'b0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
      end
    endcase
  end

  // State, PC and request registers
  always_ff @(posedge clk or negedge rst) begin : fsm_seq
    if (!rst) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      state     <= state_nxt;
      fetch_pc  <= fetch_pc_nxt;
      imem_req  <= req_nxt;
      imem_addr <= addr_nxt;
    end
  end

  // Buffer pointers and registered decode-side outputs
  always_ff @(posedge clk or negedge rst) begin : buf_seq
    if (!rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else begin
      rd_ptr      <= rd_ptr_nxt;
      wr_ptr      <= wr_ptr_nxt;
      count       <= count_nxt;
      instr_valid <= (count_nxt != '0);
      if (count_nxt != '0) begin
        instr    <= head_data_c;
        instr_pc <= head_pc_c;
      end
    end
  end

  // Buffer storage; contents are only read while the entry is valid
  always_ff @(posedge clk) begin : buf_mem
    if (push_c) begin
      mem_data[wr_ptr] <= imem_data;
      mem_pc[wr_ptr]   <= fetch_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. A memory model acks after a
// programmable number of wait cycles; kept responses are queued with their
// expected PC and compared when decode pops them.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  entry_t      sb_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_pc = RESET_PC;
  logic        drop = 1'b0;
  logic [31:0] drop_addr = 32'h0;
  int          wait_cnt = 0;
  int          mem_lat = 0;
  int          ack_cnt = 0;
  logic        ready_ctl = 1'b0;
  logic        redir_ctl = 1'b0;
  logic [31:0] redir_target = 32'h0;
  logic        ovr_valid = 1'b0;
  logic [31:0] ovr_data = 32'h0;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // One clock: drive inputs from the current sample, update the model,
  // cross the edge and check the registered results.
  task automatic step();
    logic        ack;
    logic [31:0] d;
    entry_t      e;
    ack = imem_req && (wait_cnt >= mem_lat);
    d   = ovr_valid ? ovr_data : mem_word(imem_addr);
    imem_ack    = ack;
    imem_data   = ack ? d : 32'h0;
    redirect    = redir_ctl;
    redirect_pc = redir_target;
    instr_ready = ready_ctl;
    if (instr_valid && ready_ctl && sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_eq("pop_pc", instr_pc, e.pc);
      check_eq("pop_data", instr, e.data);
    end
    if (ack) begin
      ack_cnt++;
      ovr_valid = 1'b0;
      check_eq("ack_addr", imem_addr, drop ? drop_addr : exp_pc);
      if (!drop && !redir_ctl) begin
        e.pc   = exp_pc;
        e.data = d;
        sb_q.push_back(e);
        exp_pc = exp_pc + 32'd4;
      end
    end
    if (redir_ctl) begin
      sb_q.delete();
      if (imem_req && !ack) begin
        drop      = 1'b1;
        drop_addr = imem_addr;
      end else begin
        drop = 1'b0;
      end
      exp_pc = redir_target & ~32'h0000_0003;
    end else if (ack) begin
      drop = 1'b0;
    end
    wait_cnt  = (imem_req && !ack) ? wait_cnt + 1 : 0;
    prev_req  = imem_req;
    prev_ack  = ack;
    prev_addr = imem_addr;
    @(posedge clk);
    #1;
    redir_ctl = 1'b0;
    redirect  = 1'b0;
    imem_ack  = 1'b0;
    if (prev_req && !prev_ack) begin
      check_eq("req_hold", 32'(imem_req), 32'd1);
      check_eq("addr_hold", imem_addr, prev_addr);
    end
    check_eq("valid_vs_model", 32'(instr_valid), 32'(sb_q.size() != 0));
  endtask

  task automatic model_clear();
    sb_q.delete();
    exp_pc   = RESET_PC;
    drop     = 1'b0;
    wait_cnt = 0;
    prev_req = 1'b0;
    prev_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    imem_ack    = 1'b0;
    redirect    = 1'b0;
    instr_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_clear();
  endtask

  initial begin
    logic found;
    // Reset values while rst is low
    #12;
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_addr", imem_addr, RESET_PC);
    check_eq("rst_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_instr_pc", instr_pc, 32'h0);

    // Zero-wait streaming
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_clear();
    mem_lat   = 0;
    ready_ctl = 1'b1;
    step();
    check_eq("t1_req", 32'(imem_req), 32'd1);
    check_eq("t1_addr0", imem_addr, 32'h0);
    check_eq("t1_valid0", 32'(instr_valid), 32'd0);
    step();
    check_eq("t1_addr4", imem_addr, 32'h4);
    check_eq("t1_valid1", 32'(instr_valid), 32'd1);
    check_eq("t1_pc0", instr_pc, 32'h0);
    step();
    check_eq("t1_addr8", imem_addr, 32'h8);
    check_eq("t1_pc4", instr_pc, 32'h4);
    step();
    check_eq("t1_pc8", instr_pc, 32'h8);
    repeat (6) step();

    // Full buffer stalls fetch; first pop reopens it
    do_reset();
    ready_ctl = 1'b0;
    mem_lat   = 0;
    ack_cnt   = 0;
    repeat (4) step();
    check_eq("t2_acks", 32'(ack_cnt), 32'd2);
    check_eq("t2_req_off", 32'(imem_req), 32'd0);
    check_eq("t2_head_pc", instr_pc, 32'h0);
    ready_ctl = 1'b1;
    step();
    check_eq("t2_req_on", 32'(imem_req), 32'd1);
    check_eq("t2_addr8", imem_addr, 32'h8);
    check_eq("t2_head_pc4", instr_pc, 32'h4);
    repeat (4) step();

    // Slow memory
    mem_lat = 3;
    repeat (30) step();

    // Redirect while a request to 0x8 is pending
    do_reset();
    mem_lat   = 2;
    ready_ctl = 1'b1;
    found     = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (imem_req && imem_addr == 32'h8 && wait_cnt == 0) found = 1'b1;
      else step();
    end
    check_eq("t4_reach_req8", 32'(found), 32'd1);
    redir_ctl    = 1'b1;
    redir_target = 32'h0000_0100;
    ovr_valid    = 1'b1;
    ovr_data     = 32'hDEAD_BEEF;
    step();
    check_eq("t4_hold_addr", imem_addr, 32'h8);
    check_eq("t4_flushed", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 20 && imem_addr == 32'h8; i++) step();
    check_eq("t4_new_addr", imem_addr, 32'h100);
    for (int i = 0; i < 20 && !instr_valid; i++) step();
    check_eq("t4_first_pc", instr_pc, 32'h100);
    check_eq("t4_first_word", instr, mem_word(32'h100));

    // Redirect coinciding with ack and pop; low address bits ignored
    mem_lat = 0;
    repeat (3) step();
    redir_ctl    = 1'b1;
    redir_target = 32'h0000_0203;
    step();
    check_eq("t5_empty", 32'(instr_valid), 32'd0);
    check_eq("t5_addr", imem_addr, 32'h200);
    check_eq("t5_req", 32'(imem_req), 32'd1);
    repeat (5) step();

    // Redirect from IDLE, then fetch across the address wrap
    ready_ctl = 1'b0;
    repeat (4) step();
    check_eq("t6_idle", 32'(imem_req), 32'd0);
    redir_ctl    = 1'b1;
    redir_target = 32'hFFFF_FFF8;
    step();
    check_eq("t6_req", 32'(imem_req), 32'd1);
    check_eq("t6_addr", imem_addr, 32'hFFFF_FFF8);
    check_eq("t6_empty", 32'(instr_valid), 32'd0);
    ready_ctl = 1'b1;
    repeat (8) step();

    // Asynchronous reset in the middle of a wait with a non-empty buffer
    do_reset();
    mem_lat   = 3;
    ready_ctl = 1'b0;
    repeat (6) step();
    check_eq("t7_pre_req", 32'(imem_req), 32'd1);
    check_eq("t7_pre_valid", 32'(instr_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("t7_req_drop", 32'(imem_req), 32'd0);
    check_eq("t7_valid_drop", 32'(instr_valid), 32'd0);
    check_eq("t7_addr_rst", imem_addr, RESET_PC);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_clear();
    ready_ctl = 1'b1;
    step();
    check_eq("t7_restart_req", 32'(imem_req), 32'd1);
    check_eq("t7_restart_addr", imem_addr, RESET_PC);
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
